// File: rtl/line_refill_engine.sv
// Refill engine shared by the I-cache and D-cache: round-robin grant, optional D-side victim write-back, then a line read.
// Latency: fill pulse MEM_LAT+1 cycles after the request is taken in IDLE, 2*MEM_LAT+1 when a write-back runs first.
// Backpressure: requests are level misses held by the caches; they are only sampled in IDLE and wait otherwise.
module line_refill_engine #(
    parameter int LINE_W  = 128,
    parameter int LINE_AW = 9,
    parameter int DEPTH   = 512,
    parameter int MEM_LAT = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ic_miss,
    input  logic [LINE_AW-1:0] ic_miss_addr,
    input  logic               dc_miss,
    input  logic [LINE_AW-1:0] dc_miss_addr,
    input  logic               dc_wb,
    input  logic [LINE_AW-1:0] dc_wb_addr,
    input  logic [LINE_W-1:0]  dc_wb_line,
    output logic               ic_fill,
    output logic [LINE_W-1:0]  ic_fill_line,
    output logic [LINE_AW-1:0] ic_fill_tag,
    output logic               dc_fill,
    output logic [LINE_W-1:0]  dc_fill_line,
    output logic [LINE_AW-1:0] dc_fill_tag,
    output logic               busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WORDS = LINE_W / 32;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Backing-store index: the line address wraps modulo the store depth.
    function automatic logic [IDX_W-1:0] line_idx(input logic [LINE_AW-1:0] a);
        logic [31:0] m;
        m = 32'(a) % 32'(DEPTH);
        return IDX_W'(m);
    endfunction

    // Contents of a line that has never been written: word w of line i holds i*WORDS+w.
    function automatic logic [LINE_W-1:0] init_line(input logic [IDX_W-1:0] i);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int w = 0; w < WORDS; w++) begin
            l[w*32 +: 32] = 32'(i) * 32'(WORDS) + 32'(w);
        end
        return l;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 gnt_d_q, gnt_d_d;      // 1: current job belongs to the D side
    logic                 last_d_q, last_d_d;    // 1: D side was served most recently
    logic [LINE_AW-1:0]   addr_q, addr_d;
    logic [LINE_AW-1:0]   wb_addr_q, wb_addr_d;
    logic [LINE_W-1:0]    wb_line_q, wb_line_d;
    logic [LINE_W-1:0]    ic_line_q, ic_line_d;
    logic [LINE_AW-1:0]   ic_tag_q, ic_tag_d;
    logic [LINE_W-1:0]    dc_line_q, dc_line_d;
    logic [LINE_AW-1:0]   dc_tag_q, dc_tag_d;

    // Backing store: written lines live in mem, wr_vld_q marks which ones override the
    // power-up pattern. Neither is touched by reset, so committed write-backs survive it.
    logic [LINE_W-1:0]    mem [DEPTH];
    logic [DEPTH-1:0]     wr_vld_q = '0;
    logic [DEPTH-1:0]     wr_vld_d;

    logic                 req_any;
    logic                 pick_d;
    logic                 take_wb;
    logic                 cnt_zero;
    logic                 mem_we;
    logic [IDX_W-1:0]     wb_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [LINE_W-1:0]    rd_line;

    // Arbitration and store access decode.
    always_comb begin
        req_any  = ic_miss | dc_miss;
        pick_d   = dc_miss & (~ic_miss | ~last_d_q);
        take_wb  = pick_d & dc_wb;
        cnt_zero = (cnt_q == '0);
        mem_we   = (state_q == S_WB) && cnt_zero;
        wb_idx   = line_idx(wb_addr_q);
        rd_idx   = line_idx(addr_q);
        rd_line  = wr_vld_q[rd_idx] ? mem[rd_idx] : init_line(rd_idx);
        wr_vld_d = wr_vld_q;
        if (mem_we) begin
            wr_vld_d[wb_idx] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_any) state_d = take_wb ? S_WB : S_RD;
            S_WB:   if (cnt_zero) state_d = S_RD;
            S_RD:   if (cnt_zero) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: fill strobe only in RESP, steered to the granted side.
    always_comb begin
        ic_fill = (state_q == S_RESP) && !gnt_d_q;
        dc_fill = (state_q == S_RESP) && gnt_d_q;
        busy    = (state_q != S_IDLE);
    end

    // Datapath next values: request capture, access counter, fill line/tag latching.
    always_comb begin
        cnt_d     = cnt_q;
        gnt_d_d   = gnt_d_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        wb_addr_d = wb_addr_q;
        wb_line_d = wb_line_q;
        ic_line_d = ic_line_q;
        ic_tag_d  = ic_tag_q;
        dc_line_d = dc_line_q;
        dc_tag_d  = dc_tag_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    gnt_d_d = pick_d;
                    addr_d  = pick_d ? dc_miss_addr : ic_miss_addr;
                    cnt_d   = CNT_RELOAD;
                    if (take_wb) begin
                        wb_addr_d = dc_wb_addr;
                        wb_line_d = dc_wb_line;
                    end
                end
            end
            S_WB: begin
                cnt_d = cnt_zero ? CNT_RELOAD : cnt_q - CNT_W'(1);
            end
            S_RD: begin
                if (cnt_zero) begin
                    // Read after the write-back commit, so a same-line victim is returned as written.
                    if (gnt_d_q) begin
                        dc_line_d = rd_line;
                        dc_tag_d  = addr_q;
                    end else begin
                        ic_line_d = rd_line;
                        ic_tag_d  = addr_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                last_d_d = gnt_d_q;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            gnt_d_q   <= 1'b0;
            last_d_q  <= 1'b0;
            addr_q    <= '0;
            wb_addr_q <= '0;
            wb_line_q <= '0;
            ic_line_q <= '0;
            ic_tag_q  <= '0;
            dc_line_q <= '0;
            dc_tag_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            gnt_d_q   <= gnt_d_d;
            last_d_q  <= last_d_d;
            addr_q    <= addr_d;
            wb_addr_q <= wb_addr_d;
            wb_line_q <= wb_line_d;
            ic_line_q <= ic_line_d;
            ic_tag_q  <= ic_tag_d;
            dc_line_q <= dc_line_d;
            dc_tag_q  <= dc_tag_d;
        end
    end

    // Store write port; only reachable from WB, which reset leaves immediately.
    always_ff @(posedge clk) begin
        wr_vld_q <= wr_vld_d;
        if (mem_we) begin
            mem[wb_idx] <= wb_line_q;
        end
    end

    assign ic_fill_line = ic_line_q;
    assign ic_fill_tag  = ic_tag_q;
    assign dc_fill_line = dc_line_q;
    assign dc_fill_tag  = dc_tag_q;

endmodule

// File: tb/tb_line_refill_engine.sv
// Bench for line_refill_engine: table of single requests plus arbitration, late-request and reset sequences.
// Expected fills are queued at stimulus time and checked against every fill pulse, including its cycle.
// Wide address (LINE_AW=10) so addresses beyond the store depth exercise the wrap.
module tb_line_refill_engine;

    localparam int LW = 128;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_miss;
    logic [AW-1:0] ic_miss_addr;
    logic          dc_miss;
    logic [AW-1:0] dc_miss_addr;
    logic          dc_wb;
    logic [AW-1:0] dc_wb_addr;
    logic [LW-1:0] dc_wb_line;
    logic          ic_fill;
    logic [LW-1:0] ic_fill_line;
    logic [AW-1:0] ic_fill_tag;
    logic          dc_fill;
    logic [LW-1:0] dc_fill_line;
    logic [AW-1:0] dc_fill_tag;
    logic          busy;

    line_refill_engine #(.LINE_W(LW), .LINE_AW(AW), .DEPTH(512), .MEM_LAT(5)) dut (
        .clk(clk), .reset(reset),
        .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
        .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
        .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr), .dc_wb_line(dc_wb_line),
        .ic_fill(ic_fill), .ic_fill_line(ic_fill_line), .ic_fill_tag(ic_fill_tag),
        .dc_fill(dc_fill), .dc_fill_line(dc_fill_line), .dc_fill_tag(dc_fill_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_d;
        logic [LW-1:0] line;
        logic [AW-1:0] tag;
        int            cyc;
    } exp_t;

    typedef struct {
        bit            is_d;
        logic [AW-1:0] addr;
        bit            wb;
        logic [AW-1:0] wb_addr;
        logic [LW-1:0] wb_line;
        logic [LW-1:0] exp_line;
        int            lat;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   nfill = 0;

    localparam logic [LW-1:0] PAT_A5 = 128'hA5A5_A5A5_0123_4567_89AB_CDEF_5A5A_5A5A;
    localparam logic [LW-1:0] PAT_X  = 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444;
    localparam logic [LW-1:0] PAT_Y  = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [LW-1:0] PAT_Z  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Power-up store pattern for line index i.
    function automatic logic [LW-1:0] il(input int i);
        return {32'(i * 4 + 3), 32'(i * 4 + 2), 32'(i * 4 + 1), 32'(i * 4)};
    endfunction

    // Fill monitor: every pulse must match the oldest queued expectation.
    exp_t e;
    always @(negedge clk) begin
        if (ic_fill && dc_fill) chk("fill_exclusive", LW'(ic_fill & dc_fill), '0);
        if (ic_fill || dc_fill) begin
            nfill++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_fill got ic=%0b dc=%0b exp=none (cycle %0d)", ic_fill, dc_fill, cyc);
            end else begin
                e = sbq.pop_front();
                chk("fill_side", LW'(dc_fill), LW'(e.is_d));
                chk("fill_line", e.is_d ? dc_fill_line : ic_fill_line, e.line);
                chk("fill_tag", LW'(e.is_d ? dc_fill_tag : ic_fill_tag), LW'(e.tag));
                chk("fill_cycle", LW'(cyc), LW'(e.cyc));
            end
        end
    end

    task automatic drop_all();
        ic_miss = 1'b0;
        dc_miss = 1'b0;
        dc_wb   = 1'b0;
    endtask

    task automatic wait_fills(input int target);
        int n = 0;
        while (nfill < target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (nfill < target) begin
            total++;
            bad++;
            $display("FAIL fill_timeout got=%0d exp=%0d", nfill, target);
        end
    endtask

    task automatic do_req(input bit is_d, input logic [AW-1:0] addr, input bit wb,
                          input logic [AW-1:0] wb_addr, input logic [LW-1:0] wb_line,
                          input logic [LW-1:0] exp_line, input int lat);
        int t0;
        int target;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (is_d) begin
            dc_miss      = 1'b1;
            dc_miss_addr = addr;
            dc_wb        = wb;
            dc_wb_addr   = wb_addr;
            dc_wb_line   = wb_line;
        end else begin
            ic_miss      = 1'b1;
            ic_miss_addr = addr;
        end
        sbq.push_back('{is_d, exp_line, addr, t0 + lat});
        target = nfill + 1;
        @(negedge clk);
        chk("busy_idle", LW'(busy), '0);
        @(negedge clk);
        chk("busy_active", LW'(busy), LW'(1));
        wait_fills(target);
        @(posedge clk);
        #1;
        drop_all();
        @(negedge clk);
        chk("busy_after", LW'(busy), '0);
    endtask

    vec_t vt[9];

    initial begin
        int t0;
        int base;

        vt[0] = '{1'b0, 10'd3,    1'b0, 10'd0,   '0,     {32'd15, 32'd14, 32'd13, 32'd12}, 6};
        vt[1] = '{1'b1, 10'd7,    1'b1, 10'd7,   PAT_A5, PAT_A5,  11};
        vt[2] = '{1'b0, 10'd7,    1'b0, 10'd0,   '0,     PAT_A5,  6};
        vt[3] = '{1'b1, 10'd20,   1'b0, 10'd0,   PAT_Z,  il(20),  6};
        vt[4] = '{1'b1, 10'd9,    1'b1, 10'd100, PAT_X,  il(9),   11};
        vt[5] = '{1'b0, 10'd100,  1'b0, 10'd0,   '0,     PAT_X,   6};
        vt[6] = '{1'b0, 10'd514,  1'b0, 10'd0,   '0,     il(2),   6};
        vt[7] = '{1'b1, 10'd1023, 1'b0, 10'd0,   '0,     il(511), 6};
        vt[8] = '{1'b0, 10'd0,    1'b0, 10'd0,   '0,     il(0),   6};

        reset        = 1'b1;
        ic_miss      = 1'b0;
        ic_miss_addr = '0;
        dc_miss      = 1'b0;
        dc_miss_addr = '0;
        dc_wb        = 1'b0;
        dc_wb_addr   = '0;
        dc_wb_line   = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", LW'(busy), '0);
        chk("rst_ic_fill", LW'(ic_fill), '0);
        chk("rst_dc_fill", LW'(dc_fill), '0);
        chk("rst_ic_line", ic_fill_line, '0);
        chk("rst_dc_line", dc_fill_line, '0);
        chk("rst_ic_tag", LW'(ic_fill_tag), '0);
        chk("rst_dc_tag", LW'(dc_fill_tag), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-request table.
        for (int i = 0; i < 9; i++) begin
            do_req(vt[i].is_d, vt[i].addr, vt[i].wb, vt[i].wb_addr, vt[i].wb_line,
                   vt[i].exp_line, vt[i].lat);
        end

        // Fill line/tag hold between pulses.
        repeat (3) @(negedge clk);
        chk("hold_ic_tag", LW'(ic_fill_tag), '0);
        chk("hold_dc_tag", LW'(dc_fill_tag), LW'(10'd1023));
        chk("hold_dc_line", dc_fill_line, il(511));

        // dc_wb without dc_miss is ignored.
        @(posedge clk);
        #1;
        dc_wb      = 1'b1;
        dc_wb_addr = 10'd5;
        dc_wb_line = PAT_Z;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wb_only_busy", LW'(busy), '0);
        @(posedge clk);
        #1;
        drop_all();
        do_req(1'b0, 10'd5, 1'b0, '0, '0, il(5), 6);

        // Both misses held from reset: D first, then alternating.
        @(posedge clk);
        #1;
        reset        = 1'b1;
        ic_miss      = 1'b1;
        ic_miss_addr = 10'd11;
        dc_miss      = 1'b1;
        dc_miss_addr = 10'd12;
        @(posedge clk);
        #1;
        reset = 1'b0;
        t0    = cyc;
        sbq.push_back('{1'b1, il(12), 10'd12, t0 + 6});
        sbq.push_back('{1'b0, il(11), 10'd11, t0 + 13});
        sbq.push_back('{1'b1, il(12), 10'd12, t0 + 20});
        base = nfill;
        wait_fills(base + 3);
        @(posedge clk);
        #1;
        drop_all();

        // I miss arriving while D is in RD waits for IDLE.
        repeat (2) @(posedge clk);
        #1;
        t0           = cyc;
        dc_miss      = 1'b1;
        dc_miss_addr = 10'd30;
        sbq.push_back('{1'b1, il(30), 10'd30, t0 + 6});
        base = nfill;
        repeat (2) @(posedge clk);
        #1;
        ic_miss      = 1'b1;
        ic_miss_addr = 10'd31;
        sbq.push_back('{1'b0, il(31), 10'd31, t0 + 13});
        wait_fills(base + 1);
        @(posedge clk);
        #1;
        dc_miss = 1'b0;
        wait_fills(base + 2);
        @(posedge clk);
        #1;
        drop_all();

        // Reset during write-back: the write must not commit.
        @(posedge clk);
        #1;
        dc_miss      = 1'b1;
        dc_miss_addr = 10'd40;
        dc_wb        = 1'b1;
        dc_wb_addr   = 10'd40;
        dc_wb_line   = PAT_Y;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drop_all();
        @(negedge clk);
        chk("rst_wb_busy", LW'(busy), '0);
        chk("rst_wb_dc_fill", LW'(dc_fill), '0);
        chk("rst_wb_dc_tag", LW'(dc_fill_tag), '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        do_req(1'b0, 10'd40, 1'b0, '0, '0, il(40), 6);

        // Reset during RD: no fill, state back to idle.
        @(posedge clk);
        #1;
        ic_miss      = 1'b1;
        ic_miss_addr = 10'd41;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        drop_all();
        @(negedge clk);
        chk("rst_rd_busy", LW'(busy), '0);
        chk("rst_rd_ic_fill", LW'(ic_fill), '0);
        chk("rst_rd_ic_tag", LW'(ic_fill_tag), '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_rd_idle_busy", LW'(busy), '0);
        do_req(1'b0, 10'd41, 1'b0, '0, '0, il(41), 6);

        repeat (5) @(negedge clk);
        chk("sb_empty", LW'(sbq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
